// File: rtl/mul_prod_accum_if.sv
// Stream bundle between the 8x8 multiplier feed and the product accumulator:
// a term-input handshake plus a result-output handshake.
interface mul_prod_accum_if #(
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      prod;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
    logic [7:0]       term_cnt;

    // master drives terms and takes results; slave is the accumulator
    modport master (
        output in_valid, prod, clear, out_ready,
        input  in_ready, out_valid, acc_out, ovf, term_cnt
    );

    modport slave (
        input  in_valid, prod, clear, out_ready,
        output in_ready, out_valid, acc_out, ovf, term_cnt
    );
endinterface

// File: rtl/mul_prod_accum.sv
// Sums N_TERMS consecutive 16-bit products into one ACC_W-bit dot-product result
// and presents it on a valid/ready handshake, with a sticky carry-out flag.
module mul_prod_accum #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 24
) (
    input logic              clk,
    input logic              rst,
    mul_prod_accum_if.slave  bus
);
    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [7:0] last_idx = 8'(N_TERMS - 1);

    state_t           state;
    state_t           state_nxt;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [7:0]       cnt;
    logic [ACC_W:0]   sum;
    logic             accept;
    logic             xfer;
    logic             last;

    assign accept = bus.in_valid & in_ready;
    assign xfer   = out_valid & bus.out_ready;
    assign last   = (cnt == last_idx);
    // one extra bit captures the carry out of the top accumulator bit
    assign sum    = {1'b0, acc} + (ACC_W + 1)'(bus.prod);

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = ACC;
        end else begin
            case (state)
                ACC:  if (accept && last) state_nxt = DONE;
                DONE: if (xfer)           state_nxt = ACC;
            endcase
        end
    end

    // handshake flags decode from the state register only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC:  in_ready  = 1'b1;
            DONE: out_valid = 1'b1;
        endcase
    end

    // clear outranks both a term accept and a result transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (bus.clear || xfer) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
            cnt <= cnt + 8'd1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.acc_out   = acc;
    assign bus.ovf       = ovf;
    assign bus.term_cnt  = cnt;
endmodule

// File: tb/tb_mul_prod_accum.sv
// Directed bench for mul_prod_accum: vector tables for the default (4 x 24-bit)
// and a wrapping (2 x 16-bit) instance, plus an asynchronous-reset-in-DONE sequence.
module tb_mul_prod_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mul_prod_accum_if #(.ACC_W(24)) ia ();
    mul_prod_accum_if #(.ACC_W(16)) ib ();

    mul_prod_accum #(.N_TERMS(4), .ACC_W(24)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    mul_prod_accum #(.N_TERMS(2), .ACC_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    typedef struct packed {
        logic        iv;
        logic [15:0] prod;
        logic        clr;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_acc;
        logic        e_ovf;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];

    function automatic vec_t v(input logic iv, input logic [15:0] prod, input logic clr,
                               input logic ordy, input logic e_rdy, input logic e_vld,
                               input logic [31:0] e_acc, input logic e_ovf, input logic [7:0] e_cnt);
        vec_t r;
        r = '{iv, prod, clr, ordy, e_rdy, e_vld, e_acc, e_ovf, e_cnt};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        ia.in_valid = 1'b0; ia.prod = '0; ia.clear = 1'b0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.prod = '0; ib.clear = 1'b0; ib.out_ready = 1'b0;

        // rows: inputs for this cycle, then outputs expected during this cycle
        // dot product 0xFF x {00,01,10,11}
        va.push_back(v(1, 16'h0000, 0, 1, 1, 0, 32'h000000, 0, 0));
        va.push_back(v(1, 16'h00FF, 0, 1, 1, 0, 32'h000000, 0, 1));
        va.push_back(v(1, 16'h0FF0, 0, 1, 1, 0, 32'h0000FF, 0, 2));
        va.push_back(v(1, 16'h10EF, 0, 1, 1, 0, 32'h0010EF, 0, 3));
        va.push_back(v(1, 16'h1234, 0, 1, 0, 1, 32'h0021DE, 0, 4));
        // maximum products
        va.push_back(v(1, 16'hFE01, 0, 1, 1, 0, 32'h000000, 0, 0));
        va.push_back(v(1, 16'hFE01, 0, 1, 1, 0, 32'h00FE01, 0, 1));
        va.push_back(v(1, 16'hFE01, 0, 1, 1, 0, 32'h01FC02, 0, 2));
        va.push_back(v(1, 16'hFE01, 0, 1, 1, 0, 32'h02FA03, 0, 3));
        va.push_back(v(0, 16'h0000, 0, 1, 0, 1, 32'h03F804, 0, 4));
        // backpressure, with stray in_valid pulses while DONE
        va.push_back(v(1, 16'h0000, 0, 0, 1, 0, 32'h000000, 0, 0));
        va.push_back(v(1, 16'h00FF, 0, 0, 1, 0, 32'h000000, 0, 1));
        va.push_back(v(1, 16'h0FF0, 0, 0, 1, 0, 32'h0000FF, 0, 2));
        va.push_back(v(1, 16'h10EF, 0, 0, 1, 0, 32'h0010EF, 0, 3));
        for (int k = 0; k < 5; k++)
            va.push_back(v(k[0], 16'hFFFF, 0, 0, 0, 1, 32'h0021DE, 0, 4));
        va.push_back(v(0, 16'h0000, 0, 1, 0, 1, 32'h0021DE, 0, 4));
        va.push_back(v(1, 16'h0005, 0, 0, 1, 0, 32'h000000, 0, 0));
        va.push_back(v(0, 16'h0000, 0, 0, 1, 0, 32'h000005, 0, 1));
        // clear flushes a partial sum, and beats a simultaneous term
        va.push_back(v(0, 16'h0000, 1, 0, 1, 0, 32'h000005, 0, 1));
        va.push_back(v(1, 16'h00FF, 0, 0, 1, 0, 32'h000000, 0, 0));
        va.push_back(v(1, 16'h0FF0, 0, 0, 1, 0, 32'h0000FF, 0, 1));
        va.push_back(v(1, 16'h10EF, 1, 0, 1, 0, 32'h0010EF, 0, 2));
        va.push_back(v(1, 16'h0001, 0, 0, 1, 0, 32'h000000, 0, 0));
        va.push_back(v(1, 16'h0001, 0, 0, 1, 0, 32'h000001, 0, 1));
        va.push_back(v(1, 16'h0001, 0, 0, 1, 0, 32'h000002, 0, 2));
        va.push_back(v(1, 16'h0001, 0, 0, 1, 0, 32'h000003, 0, 3));
        va.push_back(v(0, 16'h0000, 0, 1, 0, 1, 32'h000004, 0, 4));
        va.push_back(v(0, 16'h0000, 0, 0, 1, 0, 32'h000000, 0, 0));

        // 2 x 16-bit instance: wrap with sticky ovf, per-result clearing, clear in DONE
        vb.push_back(v(1, 16'hFE01, 0, 0, 1, 0, 32'h0000, 0, 0));
        vb.push_back(v(1, 16'hFE01, 0, 0, 1, 0, 32'hFE01, 0, 1));
        vb.push_back(v(0, 16'h0000, 0, 1, 0, 1, 32'hFC02, 1, 2));
        vb.push_back(v(1, 16'h0003, 0, 0, 1, 0, 32'h0000, 0, 0));
        vb.push_back(v(1, 16'h0030, 0, 0, 1, 0, 32'h0003, 0, 1));
        vb.push_back(v(0, 16'h0000, 0, 1, 0, 1, 32'h0033, 0, 2));
        vb.push_back(v(1, 16'h0001, 0, 0, 1, 0, 32'h0000, 0, 0));
        vb.push_back(v(1, 16'h0002, 0, 0, 1, 0, 32'h0001, 0, 1));
        vb.push_back(v(0, 16'h0000, 1, 1, 0, 1, 32'h0003, 0, 2));
        vb.push_back(v(0, 16'h0000, 0, 0, 1, 0, 32'h0000, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(ia.in_ready), 32'd1);
        check("reset out_valid", 32'(ia.out_valid), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < va.size(); i++) begin
            @(posedge clk); #1;
            ia.in_valid = va[i].iv; ia.prod = va[i].prod;
            ia.clear = va[i].clr; ia.out_ready = va[i].ordy;
            #1;
            check($sformatf("A[%0d] in_ready", i), 32'(ia.in_ready), 32'(va[i].e_rdy));
            check($sformatf("A[%0d] out_valid", i), 32'(ia.out_valid), 32'(va[i].e_vld));
            check($sformatf("A[%0d] acc_out", i), 32'(ia.acc_out), va[i].e_acc);
            check($sformatf("A[%0d] ovf", i), 32'(ia.ovf), 32'(va[i].e_ovf));
            check($sformatf("A[%0d] term_cnt", i), 32'(ia.term_cnt), 32'(va[i].e_cnt));
        end

        for (int i = 0; i < vb.size(); i++) begin
            @(posedge clk); #1;
            ib.in_valid = vb[i].iv; ib.prod = vb[i].prod;
            ib.clear = vb[i].clr; ib.out_ready = vb[i].ordy;
            #1;
            check($sformatf("B[%0d] in_ready", i), 32'(ib.in_ready), 32'(vb[i].e_rdy));
            check($sformatf("B[%0d] out_valid", i), 32'(ib.out_valid), 32'(vb[i].e_vld));
            check($sformatf("B[%0d] acc_out", i), 32'(ib.acc_out), vb[i].e_acc);
            check($sformatf("B[%0d] ovf", i), 32'(ib.ovf), 32'(vb[i].e_ovf));
            check($sformatf("B[%0d] term_cnt", i), 32'(ib.term_cnt), 32'(vb[i].e_cnt));
        end

        // asynchronous reset while a result is held in DONE
        @(posedge clk); #1;
        ia.in_valid = 1'b1; ia.prod = 16'h0100; ia.out_ready = 1'b0;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(posedge clk); #2;
                seen = ia.out_valid;
            end
            ia.in_valid = 1'b0;
            check("arst reached DONE", 32'(seen), 32'd1);
        end
        check("arst pre acc_out", 32'(ia.acc_out), 32'h000400);
        check("arst pre term_cnt", 32'(ia.term_cnt), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("arst out_valid", 32'(ia.out_valid), 32'd0);
        check("arst acc_out", 32'(ia.acc_out), 32'd0);
        check("arst ovf", 32'(ia.ovf), 32'd0);
        check("arst term_cnt", 32'(ia.term_cnt), 32'd0);
        check("arst in_ready", 32'(ia.in_ready), 32'd1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post arst in_ready", 32'(ia.in_ready), 32'd1);
        check("post arst acc_out", 32'(ia.acc_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
